// File: rtl/intersection_phase_ctrl.sv
// Two-approach (NS/EW) intersection phase controller with a latched pedestrian WALK
// phase, a one-second prescaler and a per-phase seconds countdown. Defining
// TL_NIGHT_FLASH_EN adds the night_mode input and a flashing-yellow FLASH state.
module intersection_phase_ctrl #(
  parameter int unsigned pSECOND_CNT_VALUE = 99,
  parameter int unsigned pNS_GREEN_VAL     = 14,
  parameter int unsigned pEW_GREEN_VAL     = 14,
  parameter int unsigned pYELLOW_VAL       = 2,
  parameter int unsigned pALL_RED_VAL      = 1,
  parameter int unsigned pWALK_VAL         = 9,
  parameter int unsigned pMIN_GREEN_VAL    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
`ifdef TL_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       ew_green,
  output logic       ew_yellow,
  output logic       ew_red,
  output logic       walk,
  output logic       ped_ack,
  output logic       sec_tick,
  output logic [6:0] count
);

  localparam int unsigned PRESC_W = (pSECOND_CNT_VALUE > 0) ? $clog2(pSECOND_CNT_VALUE + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(pSECOND_CNT_VALUE);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  localparam logic [6:0] NS_GREEN_LD = 7'(pNS_GREEN_VAL);
  localparam logic [6:0] EW_GREEN_LD = 7'(pEW_GREEN_VAL);
  localparam logic [6:0] YELLOW_LD   = 7'(pYELLOW_VAL);
  localparam logic [6:0] ALL_RED_LD  = 7'(pALL_RED_VAL);
  localparam logic [6:0] WALK_LD     = 7'(pWALK_VAL);
  localparam logic [6:0] MIN_GREEN   = 7'(pMIN_GREEN_VAL);

  typedef enum logic [2:0] {
    AR_A,
    NS_G,
    NS_Y,
    AR_B,
    EW_G,
    EW_Y,
    WALK_S
`ifdef TL_NIGHT_FLASH_EN
    , FLASH
`endif
  } state_e;

  typedef enum logic {
    DIR_NS,
    DIR_EW
  } dir_e;

  typedef struct packed {
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};

  state_e             state_q, state_d;
  dir_e               next_dir_q, next_dir_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [6:0]         count_q, count_d;
  logic               sec_tick_q, sec_tick_d;
  logic               ped_pending_q, ped_pending_d;
  logic               ped_ack_q, ped_ack_d;
  lamps_t             lamps_q, lamps_d;
`ifdef TL_NIGHT_FLASH_EN
  logic               flash_q, flash_d;
`endif

  // Sequencer proposal, used when the current second ends and nothing overrides it.
  state_e             seq_state;
  dir_e               seq_dir;
  logic [6:0]         seq_count;

  logic               tick;
  logic               enter_walk;

  function automatic lamps_t decode_lamps(input state_e st);
    lamps_t l;
    l = LAMPS_ALL_RED;
    case (st)
      NS_G:    begin l.ns_r = 1'b0; l.ns_g = 1'b1; end
      NS_Y:    begin l.ns_r = 1'b0; l.ns_y = 1'b1; end
      EW_G:    begin l.ew_r = 1'b0; l.ew_g = 1'b1; end
      EW_Y:    begin l.ew_r = 1'b0; l.ew_y = 1'b1; end
      WALK_S:  l.walk = 1'b1;
      default: l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

  // The phase logic acts on the terminal prescaler cycle itself; sec_tick is the
  // registered copy of that event, so it rises together with the resulting update.
  assign tick = en && (presc_q == PRESC_TERM);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    presc_d    = presc_q;
    sec_tick_d = tick;
    if (en) begin
      presc_d = (presc_q == PRESC_TERM) ? '0 : presc_q + PRESC_ONE;
    end
  end

  always_comb begin
    seq_state = state_q;
    seq_dir   = next_dir_q;
    seq_count = count_q - 7'd1;
    if (count_q == 7'd0) begin
      case (state_q)
        AR_A: begin
          seq_state = ped_pending_q ? WALK_S : NS_G;
          seq_count = ped_pending_q ? WALK_LD : NS_GREEN_LD;
        end
        NS_G: begin
          seq_state = NS_Y;
          seq_count = YELLOW_LD;
        end
        NS_Y: begin
          seq_state = AR_B;
          seq_count = ALL_RED_LD;
          seq_dir   = DIR_EW;
        end
        AR_B: begin
          seq_state = ped_pending_q ? WALK_S : EW_G;
          seq_count = ped_pending_q ? WALK_LD : EW_GREEN_LD;
        end
        EW_G: begin
          seq_state = EW_Y;
          seq_count = YELLOW_LD;
        end
        EW_Y: begin
          seq_state = AR_A;
          seq_count = ALL_RED_LD;
          seq_dir   = DIR_NS;
        end
        WALK_S: begin
          seq_state = (next_dir_q == DIR_NS) ? NS_G : EW_G;
          seq_count = (next_dir_q == DIR_NS) ? NS_GREEN_LD : EW_GREEN_LD;
        end
        default: begin
          seq_state = AR_A;
          seq_count = ALL_RED_LD;
          seq_dir   = DIR_NS;
        end
      endcase
    end else if ((state_q == NS_G || state_q == EW_G) && ped_pending_q
                 && (count_q > MIN_GREEN)) begin
      // A waiting pedestrian cuts the green short, but never below the minimum.
      seq_count = MIN_GREEN;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    next_dir_d = next_dir_q;
`ifdef TL_NIGHT_FLASH_EN
    flash_d    = flash_q;
`endif
    if (tick) begin
`ifdef TL_NIGHT_FLASH_EN
      if (night_mode) begin
        state_d = FLASH;
        count_d = '0;
        flash_d = (state_q == FLASH) ? ~flash_q : 1'b1;
      end else if (state_q == FLASH) begin
        state_d    = AR_A;
        count_d    = ALL_RED_LD;
        next_dir_d = DIR_NS;
        flash_d    = 1'b0;
      end else begin
        state_d    = seq_state;
        count_d    = seq_count;
        next_dir_d = seq_dir;
      end
`else
      state_d    = seq_state;
      count_d    = seq_count;
      next_dir_d = seq_dir;
`endif
    end
  end

  always_comb begin
    enter_walk    = tick && (state_q != WALK_S) && (state_d == WALK_S);
    ped_pending_d = ped_pending_q;
    // Entering WALK wins over a request in the same cycle, absorbing it.
    if (enter_walk) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != WALK_S)) begin
      ped_pending_d = 1'b1;
    end
`ifdef TL_NIGHT_FLASH_EN
    if (state_q == FLASH || state_d == FLASH) begin
      ped_pending_d = 1'b0;
    end
`endif
    ped_ack_d = enter_walk;
  end

  // Lamps are registered from the next state so they switch with the state flop.
  always_comb begin
    lamps_d = decode_lamps(state_d);
`ifdef TL_NIGHT_FLASH_EN
    if (state_d == FLASH) begin
      lamps_d      = '0;
      lamps_d.ns_y = flash_d;
      lamps_d.ew_y = flash_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= AR_A;
      next_dir_q    <= DIR_NS;
      presc_q       <= '0;
      count_q       <= ALL_RED_LD;
      sec_tick_q    <= 1'b0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
      lamps_q       <= LAMPS_ALL_RED;
`ifdef TL_NIGHT_FLASH_EN
      flash_q       <= 1'b0;
`endif
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      presc_q       <= presc_d;
      count_q       <= count_d;
      sec_tick_q    <= sec_tick_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
      lamps_q       <= lamps_d;
`ifdef TL_NIGHT_FLASH_EN
      flash_q       <= flash_d;
`endif
    end
  end

  assign ns_green  = lamps_q.ns_g;
  assign ns_yellow = lamps_q.ns_y;
  assign ns_red    = lamps_q.ns_r;
  assign ew_green  = lamps_q.ew_g;
  assign ew_yellow = lamps_q.ew_y;
  assign ew_red    = lamps_q.ew_r;
  assign walk      = lamps_q.walk;
  assign ped_ack   = ped_ack_q;
  assign sec_tick  = sec_tick_q;
  assign count     = count_q;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Self-checking bench for intersection_phase_ctrl: directed steps plus randomized
// en/ped_req, compared every cycle against a ring-of-phases reference model.
module tb_intersection_phase_ctrl;

  localparam int SEC     = 4;
  localparam int MIN_G   = 4;
  localparam int WALK_LD = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
`ifdef TL_NIGHT_FLASH_EN
  logic       night_mode = 1'b0;
`endif
  logic       ns_green, ns_yellow, ns_red;
  logic       ew_green, ew_yellow, ew_red;
  logic       walk, ped_ack, sec_tick;
  logic [6:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position on the six-phase ring AR_A,NS_G,NS_Y,AR_B,EW_G,EW_Y; a WALK
  // detour parks on the all-red slot and resumes at the following ring slot.
  int m_pos;
  int m_rem;
  int m_en_clks;
  bit m_walk, m_pend, m_ack, m_tick;

  intersection_phase_ctrl #(
    .pSECOND_CNT_VALUE(SEC - 1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .ped_req(ped_req),
`ifdef TL_NIGHT_FLASH_EN
    .night_mode(night_mode),
`endif
    .ns_green(ns_green),
    .ns_yellow(ns_yellow),
    .ns_red(ns_red),
    .ew_green(ew_green),
    .ew_yellow(ew_yellow),
    .ew_red(ew_red),
    .walk(walk),
    .ped_ack(ped_ack),
    .sec_tick(sec_tick),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int dur_of(input int pos);
    case (pos)
      1, 4:    return 14;
      2, 5:    return 2;
      default: return 1;
    endcase
  endfunction

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  function automatic logic [6:0] lamps_of(input int pos, input bit in_walk);
    if (in_walk) return 7'b0010011;
    case (pos)
      1:       return 7'b1000010;
      2:       return 7'b0100010;
      4:       return 7'b0011000;
      5:       return 7'b0010100;
      default: return 7'b0010010;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_rem = 1; m_en_clks = 0;
    m_walk = 0; m_pend = 0; m_ack = 0; m_tick = 0;
  endtask

  task automatic model_step();
    bit tk, was_walk, entered;
    tk = en && ((m_en_clks % SEC) == SEC - 1);
    if (en) m_en_clks++;
    was_walk = m_walk;
    entered  = 0;
    if (tk) begin
      if (m_rem == 0) begin
        if (m_walk) begin
          m_walk = 0;
          m_pos  = (m_pos + 1) % 6;
          m_rem  = dur_of(m_pos);
        end else if ((m_pos == 0 || m_pos == 3) && m_pend) begin
          m_walk  = 1;
          m_rem   = WALK_LD;
          entered = 1;
        end else begin
          m_pos = (m_pos + 1) % 6;
          m_rem = dur_of(m_pos);
        end
      end else if ((m_pos == 1 || m_pos == 4) && m_pend && m_rem > MIN_G) begin
        m_rem = MIN_G;
      end else begin
        m_rem--;
      end
    end
    m_pend = entered ? 1'b0 : (m_pend | (ped_req && !was_walk));
    m_ack  = entered;
    m_tick = tk;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_lamps"}, {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk},
          lamps_of(m_pos, m_walk));
    check({tag, "_count"}, count, m_rem);
    check({tag, "_sec_tick"}, sec_tick, m_tick);
    check({tag, "_ped_ack"}, ped_ack, m_ack);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all("cyc");
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");

    // Startup: 8 clocks all-red, 60 NS green, 12 NS yellow, 8 all-red, then EW green.
    #2 rst_n = 1'b1;
    en = 1'b1;
    repeat (7) cycle();
    check("startup_allred_count", count, 0);
    check("startup_allred_ns_red", ns_red, 1);
    cycle();
    check("startup_ns_green", ns_green, 1);
    check("startup_ns_count", count, 14);
    repeat (60) cycle();
    check("startup_ns_yellow", ns_yellow, 1);
    check("startup_yellow_count", count, 2);
    repeat (12) cycle();
    check("startup_allred_b", {ns_red, ew_red}, 2'b11);
    repeat (8) cycle();
    check("startup_ew_green", ew_green, 1);

    // Pedestrian truncation from NS green count 10.
    for (int i = 0; i < 400 && !(m_pos == 1 && !m_walk && m_rem == 10); i++) cycle();
    if (!(m_pos == 1 && !m_walk && m_rem == 10)) timeout_fail("wait_ns_count10");
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    for (int i = 0; i < 8 && !m_tick; i++) cycle();
    if (!m_tick) timeout_fail("wait_trunc_tick");
    check("trunc_count", count, 4);
    for (int i = 0; i < 200 && !m_walk; i++) cycle();
    if (!m_walk) timeout_fail("wait_walk");
    check("walk_lamp", walk, 1);
    check("walk_ack", ped_ack, 1);
    check("walk_count", count, 9);
    cycle();
    check("walk_ack_pulse_end", ped_ack, 0);
    repeat (39) cycle();
    check("after_walk_ew_green", ew_green, 1);
    check("after_walk_walk_off", walk, 0);

    // Enable freeze mid-second in EW green at count 7.
    for (int i = 0; i < 200 && !(m_pos == 4 && !m_walk && m_rem == 7); i++) cycle();
    if (!(m_pos == 4 && m_rem == 7)) timeout_fail("wait_ew_count7");
    cycle();
    en = 1'b0;
    repeat (50) cycle();
    check("freeze_count", count, 7);
    check("freeze_ew_green", ew_green, 1);
    en = 1'b1;
    repeat (12) cycle();

    // Randomized en / ped_req against the model.
    repeat (3000) begin
      en      = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 29) == 0);
      cycle();
    end
    en = 1'b1;
    ped_req = 1'b0;

    // Asynchronous reset during EW yellow with a request pending.
    for (int i = 0; i < 400 && !(m_pos == 5 && !m_walk); i++) cycle();
    if (!(m_pos == 5)) timeout_fail("wait_ew_yellow");
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    check("async_reset_ew_yellow", ew_yellow, 0);
    #2 rst_n = 1'b1;
    repeat (8) cycle();
    check("post_reset_ns_green", ns_green, 1);
    check("post_reset_no_walk", walk, 0);

`ifdef TL_NIGHT_FLASH_EN
    // Night flash from NS green: yellows toggle every second, reds off.
    night_mode = 1'b1;
    for (int i = 0; i < 8 && !ns_yellow; i++) begin @(posedge clk); #1; end
    if (!ns_yellow) timeout_fail("wait_flash");
    check("flash_ew_yellow", ew_yellow, 1);
    check("flash_reds", {ns_red, ew_red}, 2'b00);
    check("flash_count", count, 0);
    repeat (SEC) begin @(posedge clk); #1; end
    check("flash_toggle_off", {ns_yellow, ew_yellow}, 2'b00);
    repeat (SEC) begin @(posedge clk); #1; end
    check("flash_toggle_on", {ns_yellow, ew_yellow}, 2'b11);
    night_mode = 1'b0;
    for (int i = 0; i < 8 && !ns_red; i++) begin @(posedge clk); #1; end
    if (!ns_red) timeout_fail("wait_flash_exit");
    check("flash_exit_count", count, 1);
    check("flash_exit_ew_red", ew_red, 1);
    check("flash_exit_yellow", ns_yellow, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
